// File: rtl/disk_arb_pkg.sv
// Package: disk_arb_pkg
// Shared types and helpers for the disk arbiter.
//   state_e    - arbiter FSM states (idle / issue / wait / done)
//   RW_*       - per-requester command encodings on iReqRW
//   MaxReq     - largest supported requester count
//   req_idx_t  - requester index, wide enough for MaxReq
//   onehot()   - index to one-hot vector (MaxReq wide; callers size-cast)
package disk_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;

  localparam int unsigned MaxReq = 8;

  typedef logic [2:0] req_idx_t;

  function automatic logic [MaxReq-1:0] onehot(input req_idx_t idx);
    logic [MaxReq-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/disk_arbiter_if.sv
// Interface: disk_arbiter_if
// Handshake bus between the arbiter and the block-storage backend.
//   lba  - backend sector address, held from issue until completion
//   rd   - 1-cycle read strobe
//   wr   - 1-cycle write strobe
//   done - backend completion pulse
//   err  - backend error, sampled with done
// Modports: master (arbiter side), slave (backend side).
interface disk_arbiter_if #(
  parameter int unsigned BLBAW = 24
) ();

  logic [BLBAW-1:0] lba;
  logic             rd;
  logic             wr;
  logic             done;
  logic             err;

  modport master (
    output lba,
    output rd,
    output wr,
    input  done,
    input  err
  );

  modport slave (
    input  lba,
    input  rd,
    input  wr,
    output done,
    output err
  );

endinterface

// File: rtl/rr_picker.sv
// Module: rr_picker
// Combinational round-robin selector: returns the first pending requester
// strictly after the last granted one, wrapping around.
// Ports:
//   pend  in  NREQ   pending request flags
//   last  in  idx    index of the most recently served requester
//   g     out idx    selected requester (meaningful only when valid)
//   valid out 1      at least one request is pending
module rr_picker
  import disk_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] pend,
  input  req_idx_t        last,
  output req_idx_t        g,
  output logic            valid
);

  logic [MaxReq-1:0] pend_ext;
  req_idx_t          cand;

  always_comb begin
    pend_ext           = '0;
    pend_ext[NREQ-1:0] = pend;
    cand               = '0;
    g                  = '0;
    valid              = 1'b0;
    // Walk last+1 .. last+NREQ so the previous owner has lowest priority.
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = req_idx_t'((int'(last) + i) % int'(NREQ));
      if (!valid && pend_ext[cand]) begin
        g     = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disk_arbiter.sv
// Module: disk_arbiter
// Shares one block-storage backend between NREQ disk front-ends. Each
// front-end pulses a read or write with a sector LBA; the request is latched
// and served round-robin. The LBA is offset by the requester's image base,
// the backend handshake is run, and a 1-cycle ack (with error flag) returns
// to the owner. All outputs are registered.
// Ports:
//   iClk       in   1            system clock
//   iRst       in   1            asynchronous active-low reset
//   iReqRW     in   2*NREQ       per-requester pulse: 10 read, 01 write
//   iLBA       in   LBAW*NREQ    per-requester sector LBA, sampled with iReqRW
//   iBase      in   BLBAW*NREQ   per-requester image base (sampled in idle)
//   oAckRW     out  NREQ         1-cycle completion pulse to the owner
//   oErr       out  NREQ         error flag, valid with oAckRW
//   oGrant     out  NREQ         one-hot owner, held issue..done
//   oBusy      out  1            arbiter not idle
//   back       master modport    backend bus (lba, rd, wr, done, err)
// Configuration:
//   DISK_ARB_TIMEOUT_EN - when defined, a backend that stays silent for
//   TIMEOUT cycles in the wait state completes the transfer with an error.
module disk_arbiter
  import disk_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LBAW    = 12,
  parameter int unsigned BLBAW   = 24,
  parameter int unsigned TIMEOUT = 32'd1048576
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [2*NREQ-1:0]       iReqRW,
  input  logic [LBAW*NREQ-1:0]    iLBA,
  input  logic [BLBAW*NREQ-1:0]   iBase,
  output logic [NREQ-1:0]         oAckRW,
  output logic [NREQ-1:0]         oErr,
  output logic [NREQ-1:0]         oGrant,
  output logic                    oBusy,
  disk_arbiter_if.master          back
);

  if (NREQ < 1 || NREQ > MaxReq) begin : g_bad_nreq
    $error("disk_arbiter: NREQ must be in 1..8");
  end
  if (BLBAW < LBAW) begin : g_bad_blbaw
    $error("disk_arbiter: BLBAW must be >= LBAW");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("disk_arbiter: TIMEOUT must be >= 1");
  end

  state_e                  state_q, state_d;
  logic [NREQ-1:0]         pend_q, pend_d;
  logic [NREQ-1:0]         dir_q, dir_d;      // 1 = read
  logic [LBAW*NREQ-1:0]    lba_q, lba_d;
  req_idx_t                g_q, g_d;
  req_idx_t                last_q, last_d;
  logic [NREQ-1:0]         grant_q, grant_d;
  logic [NREQ-1:0]         ack_q, ack_d;
  logic [NREQ-1:0]         err_q, err_d;
  logic                    busy_q, busy_d;
  logic [BLBAW-1:0]        back_lba_q, back_lba_d;
  logic                    back_rd_q, back_rd_d;
  logic                    back_wr_q, back_wr_d;

  req_idx_t                pick_g;
  logic                    pick_valid;
  logic [BLBAW-1:0]        sel_base;
  logic [LBAW-1:0]         sel_lba;
  logic                    sel_dir;
  logic                    done_hit;
  logic                    tmo_hit;

  rr_picker #(
    .NREQ (NREQ)
  ) u_rr_picker (
    .pend  (pend_q),
    .last  (last_q),
    .g     (pick_g),
    .valid (pick_valid)
  );

  assign done_hit = (state_q == StWait) && back.done;

`ifdef DISK_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;

  // Held at zero outside the wait state, so it restarts on every wait entry.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      cnt_q <= '0;
    end else if (state_q != StWait) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == StWait) && !back.done && (cnt_q == CntW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Request capture. A requester being acked this cycle may re-request.
  always_comb begin
    pend_d = pend_q;
    dir_d  = dir_q;
    lba_d  = lba_q;
    for (int k = 0; k < int'(NREQ); k++) begin
      logic [1:0] rw;
      logic       is_req;
      rw     = iReqRW[2*k +: 2];
      is_req = (rw == RW_RD) || (rw == RW_WR);
      if (ack_q[k]) begin
        pend_d[k] = 1'b0;
      end
      if (is_req && (!pend_q[k] || ack_q[k])) begin
        pend_d[k]              = 1'b1;
        dir_d[k]               = (rw == RW_RD);
        lba_d[k*LBAW +: LBAW]  = iLBA[k*LBAW +: LBAW];
      end
    end
  end

  // Operand muxes: base/LBA follow the candidate, direction follows the owner.
  always_comb begin
    sel_base = '0;
    sel_lba  = '0;
    sel_dir  = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (pick_g == req_idx_t'(k)) begin
        sel_base = iBase[k*BLBAW +: BLBAW];
        sel_lba  = lba_q[k*LBAW +: LBAW];
      end
      if (g_q == req_idx_t'(k)) begin
        sel_dir = dir_q[k];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (done_hit || tmo_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, computed one cycle ahead and registered below.
  always_comb begin
    g_d        = g_q;
    last_d     = last_q;
    grant_d    = grant_q;
    back_lba_d = back_lba_q;
    back_rd_d  = 1'b0;
    back_wr_d  = 1'b0;
    ack_d      = '0;
    err_d      = '0;
    busy_d     = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          g_d        = pick_g;
          grant_d    = NREQ'(onehot(pick_g));
          back_lba_d = sel_base + BLBAW'(sel_lba);
        end
      end
      StIssue: begin
        back_rd_d = sel_dir;
        back_wr_d = ~sel_dir;
      end
      StWait: begin
        if (done_hit || tmo_hit) begin
          ack_d = NREQ'(onehot(g_q));
          err_d = (tmo_hit || back.err) ? NREQ'(onehot(g_q)) : '0;
        end
      end
      StDone: begin
        last_d  = g_q;
        grant_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      pend_q     <= '0;
      dir_q      <= '0;
      lba_q      <= '0;
      g_q        <= '0;
      last_q     <= req_idx_t'(NREQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      back_lba_q <= '0;
      back_rd_q  <= 1'b0;
      back_wr_q  <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      dir_q      <= dir_d;
      lba_q      <= lba_d;
      g_q        <= g_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      back_lba_q <= back_lba_d;
      back_rd_q  <= back_rd_d;
      back_wr_q  <= back_wr_d;
    end
  end

  assign oAckRW   = ack_q;
  assign oErr     = err_q;
  assign oGrant   = grant_q;
  assign oBusy    = busy_q;
  assign back.lba = back_lba_q;
  assign back.rd  = back_rd_q;
  assign back.wr  = back_wr_q;

endmodule

// File: tb/tb_disk_arbiter.sv
// Testbench: tb_disk_arbiter
// Directed self-checking bench for disk_arbiter (NREQ=2). Inputs are driven
// and outputs sampled on the falling clock edge. The timeout scenario runs
// only when DISK_ARB_TIMEOUT_EN is defined.
module tb_disk_arbiter;
  import disk_arb_pkg::*;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned LBAW    = 12;
  localparam int unsigned BLBAW   = 24;
  localparam int unsigned TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [2*NREQ-1:0]     req_rw;
  logic [LBAW*NREQ-1:0]  lba;
  logic [BLBAW*NREQ-1:0] base;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       err;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  disk_arbiter_if #(.BLBAW(BLBAW)) bif ();

  disk_arbiter #(
    .NREQ    (NREQ),
    .LBAW    (LBAW),
    .BLBAW   (BLBAW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .iClk   (clk),
    .iRst   (rst_n),
    .iReqRW (req_rw),
    .iLBA   (lba),
    .iBase  (base),
    .oAckRW (ack),
    .oErr   (err),
    .oGrant (grant),
    .oBusy  (busy),
    .back   (bif)
  );

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act;
    logic [1:0] expg;

    req_rw   = '0;
    lba      = '0;
    base     = {24'h200000, 24'h001000};
    bif.done = 1'b0;
    bif.err  = 1'b0;

    // Reset state
    step(2);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd", 32'(bif.rd), 32'h0);
    chk("rst_wr", 32'(bif.wr), 32'h0);
    chk("rst_lba", 32'(bif.lba), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Single read from requester 0 (cycle t)
    req_rw = {RW_NONE, RW_RD};
    lba    = {12'h000, 12'h025};
    step();                                          // t+1
    req_rw = '0;
    chk("t1_busy_early", 32'(busy), 32'h0);
    step();                                          // t+2 issue
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_lba", 32'(bif.lba), 32'h001025);
    chk("t1_rd_early", 32'(bif.rd), 32'h0);
    step();                                          // t+3 strobe
    chk("t1_rd", 32'(bif.rd), 32'h1);
    chk("t1_wr", 32'(bif.wr), 32'h0);
    step();                                          // t+4
    chk("t1_rd_pulse", 32'(bif.rd), 32'h0);
    bif.done = 1'b1;
    step();                                          // t+5 ack
    bif.done = 1'b0;
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_err", 32'(err), 32'h0);
    chk("t1_grant_done", 32'(grant), 32'h1);
    step();                                          // t+6
    chk("t1_ack_pulse", 32'(ack), 32'h0);
    chk("t1_grant_clr", 32'(grant), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);

    // Reset during wait (cycle u)
    req_rw = {RW_RD, RW_NONE};
    lba    = {12'h0AB, 12'h000};
    step();                                          // u+1
    req_rw = '0;
    step();                                          // u+2 issue
    chk("t5_grant", 32'(grant), 32'h2);
    chk("t5_lba", 32'(bif.lba), 32'h2000AB);
    step();                                          // u+3 strobe, in wait
    chk("t5_rd", 32'(bif.rd), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_rd", 32'(bif.rd), 32'h0);
    step();                                          // u+4 late backend done
    rst_n    = 1'b1;
    bif.done = 1'b1;
    step();                                          // u+5
    bif.done = 1'b0;
    chk("t5_no_ack", 32'(ack), 32'h0);
    req_rw = {2'b11, RW_NONE};                       // 11 must be ignored
    step();
    req_rw = '0;
    act = 0;
    repeat (4) begin
      if (busy || ack != '0 || bif.rd || bif.wr) act++;
      step();
    end
    chk("t5_quiet", 32'(act), 32'h0);

    // Contention after reset: last=1 so requester 0 goes first (cycle v)
    req_rw = {RW_RD, RW_WR};
    lba    = {12'h111, 12'h010};
    step();                                          // v+1
    req_rw = '0;
    step();                                          // v+2
    chk("t2_grant0", 32'(grant), 32'h1);
    chk("t2_lba0", 32'(bif.lba), 32'h001010);
    step();                                          // v+3
    chk("t2_wr0", 32'(bif.wr), 32'h1);
    chk("t2_rd0", 32'(bif.rd), 32'h0);
    bif.done = 1'b1;
    step();                                          // v+4
    bif.done = 1'b0;
    chk("t2_ack0", 32'(ack), 32'h1);
    step();                                          // v+5
    chk("t2_gap_busy", 32'(busy), 32'h0);
    step();                                          // v+6
    chk("t2_grant1", 32'(grant), 32'h2);
    chk("t2_lba1", 32'(bif.lba), 32'h200111);
    step();                                          // v+7, 4 cycles after first strobe
    chk("t2_rd1", 32'(bif.rd), 32'h1);
    chk("t2_wr1", 32'(bif.wr), 32'h0);
    bif.done = 1'b1;
    step();                                          // v+8
    bif.done = 1'b0;
    chk("t2_ack1", 32'(ack), 32'h2);
    chk("t2_err1", 32'(err), 32'h0);
    step();

    // Error completion plus a duplicate request while pending (cycle w)
    req_rw = {RW_RD, RW_NONE};
    lba    = {12'h300, 12'h000};
    step();                                          // w+1 duplicate write
    req_rw = {RW_WR, RW_NONE};
    lba    = {12'h3FF, 12'h000};
    step();                                          // w+2 issue
    req_rw = '0;
    chk("t4_grant", 32'(grant), 32'h2);
    chk("t4_lba", 32'(bif.lba), 32'h200300);
    step();                                          // w+3
    chk("t4_rd", 32'(bif.rd), 32'h1);
    chk("t4_wr", 32'(bif.wr), 32'h0);
    bif.done = 1'b1;
    bif.err  = 1'b1;
    step();                                          // w+4
    bif.done = 1'b0;
    bif.err  = 1'b0;
    chk("t4_ack", 32'(ack), 32'h2);
    chk("t4_err", 32'(err), 32'h2);
    step();
    chk("t4_err_clr", 32'(err), 32'h0);
    act = 0;
    repeat (6) begin
      if (bif.rd || bif.wr) act++;
      step();
    end
    chk("t4_single_strobe", 32'(act), 32'h0);

    // Round-robin: each requester re-requests in its own ack cycle
    req_rw = {RW_RD, RW_RD};
    lba    = {12'h020, 12'h010};
    step();
    req_rw = '0;
    for (int i = 0; i < 8; i++) begin
      expg = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();                                        // issue
      chk($sformatf("t3_grant%0d", i), 32'(grant), 32'(expg));
      step();                                        // strobe
      chk($sformatf("t3_rd%0d", i), 32'(bif.rd), 32'h1);
      bif.done = 1'b1;
      step();                                        // ack
      bif.done = 1'b0;
      chk($sformatf("t3_ack%0d", i), 32'(ack), 32'(expg));
      if (i < 6) req_rw = (i % 2 == 0) ? {RW_NONE, RW_RD} : {RW_RD, RW_NONE};
      step();                                        // idle
      req_rw = '0;
    end
    step();
    chk("t3_drained", 32'(busy), 32'h0);

`ifdef DISK_ARB_TIMEOUT_EN
    // Watchdog: backend never answers (cycle y)
    req_rw = {RW_NONE, RW_WR};
    lba    = {12'h000, 12'h001};
    step();
    req_rw = '0;
    step(2);                                         // y+3 = wait entry
    chk("t6_wr", 32'(bif.wr), 32'h1);
    step(15);                                        // entry+15
    chk("t6_no_ack_yet", 32'(ack), 32'h0);
    chk("t6_busy", 32'(busy), 32'h1);
    step();                                          // entry+16
    chk("t6_ack", 32'(ack), 32'h1);
    chk("t6_err", 32'(err), 32'h1);
    step();
    chk("t6_idle", 32'(busy), 32'h0);
    bif.done = 1'b1;
    step();
    bif.done = 1'b0;
    chk("t6_late_done", 32'(ack), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
